mul_div_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits beside the combinational execute stage: the decoder drives `start` with the R-type funct code and the rs/rt operands, and stalls the pipeline on `stall`.
- Width is parametrised; one result bit is produced per cycle.

---
 rtl/mul_div_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   It handles MULT/MULTU/DIV/DIVU in WORD_SIZE cycles, producing one bit per
//   cycle. MTHI/MTLO complete in a single cycle. MFHI/MFLO are combinational
//   reads through read_data.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   start, funct      : request valid and MIPS R-type funct code
//   operand_a/b       : rs / rt values
//   busy              : multi-cycle operation in flight
//   stall             : start with a recognised funct while busy
//   done              : one-cycle pulse when a new HI/LO result is written
//   read_data         : HI for MFHI, otherwise LO
//   hi, lo            : architectural HI/LO registers
//
// WORD_SIZE must be >= 4.
module mul_div_unit #(
  parameter int WORD_SIZE = 32,
  parameter int COUNT_W   = $clog2(WORD_SIZE+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           funct,
  input  logic [WORD_SIZE-1:0] operand_a,
  input  logic [WORD_SIZE-1:0] operand_b,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [WORD_SIZE-1:0] read_data,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Operation context captured at acceptance
  typedef struct packed {
    logic is_div;    // 1: divide, 0: multiply
    logic neg_q;     // negate product (mult) or quotient (div)
    logic neg_r;     // negate remainder (dividend was negative)
    logic div_zero;  // divisor was zero
  } op_ctx_t;

  state_t                 state, state_n;
  logic [COUNT_W-1:0]     cnt, cnt_n;
  // Shared iteration datapath:
  //   mult: acc_hi = partial product high, acc_lo = multiplier shifting out /
  //         product low shifting in, opnd = multiplicand magnitude
  //   div : acc_hi = partial remainder, acc_lo = dividend shifting out /
  //         quotient shifting in, opnd = divisor magnitude
  logic [WORD_SIZE-1:0]   acc_hi, acc_hi_n;
  logic [WORD_SIZE-1:0]   acc_lo, acc_lo_n;
  logic [WORD_SIZE-1:0]   opnd, opnd_n;
  logic [WORD_SIZE-1:0]   a_raw, a_raw_n;
  op_ctx_t                ctx, ctx_n;
  logic [WORD_SIZE-1:0]   hi_n, lo_n;
  logic                   done_n;

  function automatic logic [WORD_SIZE-1:0] mag(input logic [WORD_SIZE-1:0] x);
    return x[WORD_SIZE-1] ? (~x + 1'b1) : x;
  endfunction

  // ---------------- combinational outputs ----------------
  logic known_funct;
  always_comb begin
    known_funct = 1'b0;
    case (funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: known_funct = 1'b1;
      default:                        known_funct = 1'b0;
    endcase
  end

  assign busy      = (state == S_RUN);
  assign stall     = start && busy && known_funct;
  assign read_data = (funct == F_MFHI) ? hi : lo;

  // ---------------- one iteration step ----------------
  // Shift-add multiply: add multiplicand when multiplier LSB set, shift the
  // {carry, acc_hi, acc_lo} triple right by one.
  logic [WORD_SIZE:0]   mul_sum;
  logic [WORD_SIZE-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi  = mul_sum[WORD_SIZE:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WORD_SIZE-1:1]};

  // Restoring divide: shift next dividend bit into the remainder and subtract
  // if it fits. The difference always fits in WORD_SIZE bits when taken.
  logic [WORD_SIZE:0]   div_rs;
  logic [WORD_SIZE-1:0] div_diff, div_hi, div_lo;
  logic                 div_ge;
  assign div_rs   = {acc_hi, acc_lo[WORD_SIZE-1]};
  assign div_ge   = (div_rs >= {1'b0, opnd});
  assign div_diff = div_rs[WORD_SIZE-1:0] - opnd;
  assign div_hi   = div_ge ? div_diff : div_rs[WORD_SIZE-1:0];
  assign div_lo   = {acc_lo[WORD_SIZE-2:0], div_ge};

  // ---------------- final result selection ----------------
  logic [2*WORD_SIZE-1:0] prod, prod_fin;
  logic [WORD_SIZE-1:0]   q_fin, r_fin;
  assign prod     = {mul_hi, mul_lo};
  assign prod_fin = ctx.neg_q ? -prod : prod;
  assign q_fin    = ctx.neg_q ? -div_lo : div_lo;
  assign r_fin    = ctx.neg_r ? -div_hi : div_hi;

  // ---------------- next state ----------------
  logic                 is_signed;
  logic [WORD_SIZE-1:0] a_mag, b_mag;
  logic                 sign_diff;
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign a_mag     = is_signed ? mag(operand_a) : operand_a;
  assign b_mag     = is_signed ? mag(operand_b) : operand_b;
  assign sign_diff = is_signed && (operand_a[WORD_SIZE-1] ^ operand_b[WORD_SIZE-1]);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    opnd_n   = opnd;
    a_raw_n  = a_raw;
    ctx_n    = ctx;
    hi_n     = hi;
    lo_n     = lo;
    done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          case (funct)
            F_MTHI: hi_n = operand_a;
            F_MTLO: lo_n = operand_a;
            F_MULT, F_MULTU: begin
              state_n        = S_RUN;
              cnt_n          = COUNT_W'(WORD_SIZE);
              acc_hi_n       = '0;
              acc_lo_n       = b_mag;
              opnd_n         = a_mag;
              a_raw_n        = operand_a;
              ctx_n          = '0;
              ctx_n.neg_q    = sign_diff;
            end
            F_DIV, F_DIVU: begin
              state_n        = S_RUN;
              cnt_n          = COUNT_W'(WORD_SIZE);
              acc_hi_n       = '0;
              acc_lo_n       = a_mag;
              opnd_n         = b_mag;
              a_raw_n        = operand_a;
              ctx_n.is_div   = 1'b1;
              ctx_n.neg_q    = sign_diff;
              ctx_n.neg_r    = is_signed && operand_a[WORD_SIZE-1];
              ctx_n.div_zero = (operand_b == '0);
            end
            default: ;  // MFHI/MFLO are combinational; unknown funct ignored
          endcase
        end
      end

      S_RUN: begin
        // Inputs are ignored here; stall holds the pipeline instead.
        acc_hi_n = ctx.is_div ? div_hi : mul_hi;
        acc_lo_n = ctx.is_div ? div_lo : mul_lo;
        cnt_n    = cnt - COUNT_W'(1);
        if (cnt == COUNT_W'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          if (!ctx.is_div) begin
            hi_n = prod_fin[2*WORD_SIZE-1:WORD_SIZE];
            lo_n = prod_fin[WORD_SIZE-1:0];
          end else if (ctx.div_zero) begin
            hi_n = a_raw;
            lo_n = '1;
          end else begin
            hi_n = r_fin;
            lo_n = q_fin;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      ctx    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      opnd   <= opnd_n;
      a_raw  <= a_raw_n;
      ctx    <= ctx_n;
      hi     <= hi_n;
      lo     <= lo_n;
      done   <= done_n;
    end
  end

endmodule
